tv_runner: RTL

//   Synthesizable test-vector runner: stores {inputs, expected} vectors, applies

---
 rtl/tv_runner.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/tv_runner.sv
// tv_runner: synthesizable test-vector runner.
// Holds {inputs, expected} vectors in an internal memory, applies them one at a
// time to a combinational DUT, compares the response after a settle period and
// tracks the mismatch count and the first failing vector index.
module tv_runner #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 1,
  parameter int DEPTH  = 1024,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [10:0]           wr_addr,
  input  logic [IN_W+OUT_W-1:0] wr_data,
  input  logic [10:0]           num_tests,
  input  logic                  start,
  output logic [IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]      dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [10:0]           vec_ind,
  output logic [10:0]           num_errors,
  output logic                  err_pulse,
  output logic [10:0]           first_fail,
  output logic                  fail_valid
);

  localparam int VW = IN_W + OUT_W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [11:0]   DEPTH_X     = 12'(DEPTH);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [10:0]     vec_q, vec_d;
  logic [10:0]     nerr_q, nerr_d;
  logic [10:0]     ff_q, ff_d;
  logic            fv_q, fv_d;
  logic [10:0]     num_q, num_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0] dut_in_q;
  logic [OUT_W-1:0] exp_q;

  logic [VW-1:0]   mem [DEPTH];

  logic            accept_ok;
  logic            wr_in_range;
  logic            mismatch;
  logic [10:0]     num_clamped;
  logic [AW-1:0]   rd_idx;

  assign accept_ok   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
  assign mismatch    = (dut_out != exp_q);
  assign num_clamped = ({1'b0, num_tests} > DEPTH_X) ? DEPTH_X[10:0] : num_tests;
  assign rd_idx      = vec_q[AW-1:0];

  // Vector memory write port; only open while no run is in progress.
  always_ff @(posedge clk) begin
    if (wr_en && accept_ok && wr_in_range) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // Synchronous read in FETCH lands directly in the stimulus/expected registers,
  // so dut_in changes exactly on entry to APPLY and is held until the next FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dut_in_q <= '0;
      exp_q    <= '0;
    end else if (state_q == S_FETCH) begin
      dut_in_q <= mem[rd_idx][VW-1:OUT_W];
      exp_q    <= mem[rd_idx][OUT_W-1:0];
    end
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      nerr_q  <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
      num_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      nerr_q  <= nerr_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: run sequencing, settle timing and mismatch bookkeeping.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    nerr_d  = nerr_q;
    ff_d    = ff_q;
    fv_d    = fv_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d   = '0;
          nerr_d  = '0;
          ff_d    = '0;
          fv_d    = 1'b0;
          cnt_d   = '0;
          num_d   = num_clamped;
          state_d = (num_tests == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        cnt_d   = '0;
        state_d = S_APPLY;
      end
      S_APPLY: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (nerr_q != '1) begin
            nerr_d = nerr_q + 11'd1;
          end
          if (!fv_q) begin
            ff_d = vec_q;
            fv_d = 1'b1;
          end
        end
        vec_d   = vec_q + 11'd1;
        state_d = (vec_d == num_q) ? S_DONE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dut_in     = dut_in_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_APPLY) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign pass       = done && (nerr_q == '0);
  assign vec_ind    = vec_q;
  assign num_errors = nerr_q;
  assign err_pulse  = (state_q == S_CHECK) && mismatch;
  assign first_fail = ff_q;
  assign fail_valid = fv_q;

endmodule
